module_sub_seq: RTL and testbench
=================================

# module_sub_seq

Parametrised sequential subtractor/comparator for the password datapath: computes registered-password minus typed-password (A − B) over several clock cycles, STEP bits per cycle. It also offers an early-exit magnitude-compare mode. It replaces the fixed 4-bit ripple subtractor where wider codes or a shared narrow slice are needed. The unlock controller drives it through a Start/Busy/Done handshake.

## Interface
- WIDTH, 4: operand width in bits; ≥ 2.
- STEP, 1: bits processed per cycle; must divide WIDTH; N = WIDTH/STEP.
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Mode  in  1  0 = subtract, 1 = compare; captured with Start.
- A  in  WIDTH  minuend (registered password); captured with Start.
- B  in  WIDTH  subtrahend (typed password); captured with Start.
- Busy  out  1  high in RUN and DONE.
- Done  out  1  one-cycle completion pulse.
- Out  out  WIDTH+1  Out[WIDTH-1:0] = (A−B) mod 2^WIDTH; Out[WIDTH] = final borrow.
- Equal, Less, Greater  out  1 each  A==B, A<B, A>B; exactly one is high after any completion.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on an edge with Start=1, capture A, B and Mode, clear the borrow and chunk counter, and go to RUN.
- RUN, subtract mode: process chunks LSB-first. Each edge subtracts one STEP-bit chunk with the running borrow and shifts the result into an internal register. After chunk N−1, go to DONE.
- RUN, compare mode: process chunks MSB-first. At the first chunk where A≠B, set Greater or Less and go to DONE immediately. If all N chunks are equal, set Equal and go to DONE after chunk N−1.
- DONE: assert Done for one cycle and return to IDLE.
- Out is updated only on the edge entering DONE, and only in subtract mode. Compare mode leaves Out unchanged.
- Flags are updated on the edge entering DONE in both modes. In subtract mode: Less = borrow; Equal = difference is zero and borrow is 0; Greater = otherwise.
- Out and the flags hold their values until the next completion or reset.
- Start while Busy (RUN or DONE) is ignored and not queued. A/B/Mode changes after capture have no effect.
- Reset_n low at any time: immediately go to IDLE and clear all outputs, Out and the flags to 0 (so no flag is high). An aborted operation never pulses Done.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Let edge k sample Start=1. Busy rises after edge k.
- Subtract: chunks are processed at edges k+1..k+N. Done is high in the cycle after edge k+N. Busy falls after edge k+N+1.
- Compare: the chunk at index j (1 = MSB chunk) is processed at edge k+j. Exit is at the first differing j, or at j=N when equal. Done is high in the cycle after edge k+j.
- Minimum spacing between accepted Starts is N+2 cycles for subtract and j+2 cycles for compare. A Start is accepted in the first IDLE cycle after DONE.

## Structure
- Shared package sub_pkg holds:
  - state encodings IDLE/RUN/DONE;
  - mode constants MODE_SUB/MODE_CMP;
  - the rule "STEP divides WIDTH", checked at elaboration.
- Sub-module sub_cell: combinational STEP-bit ripple-borrow slice with inputs (a, b, borrow_in) and outputs (diff, borrow_out). Instantiate it once and reuse it every cycle.
- The top level holds the FSM, the chunk counter (clog2(N)+1 bits), the operand shift registers and the result register.

## Test plan
- WIDTH=4, STEP=1, subtract, A=9, B=3 → Out=5'b0_0110, Greater=1, Done exactly in the cycle after edge k+4, Busy for 5 cycles.
- WIDTH=4, STEP=1, subtract, A=3, B=9 → Out=5'b1_1010, Less=1.
- WIDTH=4, STEP=1, compare, A=4'b1000, B=4'b0111 → Done in the cycle after edge k+1, Greater=1, Out unchanged from the previous result. With A=B=5 → Done after edge k+4, Equal=1.
- WIDTH=8, STEP=2, subtract, A=0, B=1 → Out=9'h1FF, Less=1, Done after edge k+4. Then A=B=8'hA5 → Out=9'h000, Equal=1.
- Start pulsed during RUN and during DONE → ignored: one Done pulse only, result from the first operands.
- Reset_n asserted at edge k+2 of a subtract → outputs 0 immediately, no Done. The next Start completes normally with correct Out.

Source files
------------

// File: rtl/sub_pkg.sv
// sub_pkg: shared state/mode encodings and parameter rule for the sequential subtractor
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_CMP = 1'b1;

    function automatic bit step_divides(input int w, input int s);
        return s > 0 && w >= 2 && w % s == 0;
    endfunction

endpackage

// File: rtl/module_sub_seq_cell.sv
// sub_cell: combinational STEP-bit ripple-borrow subtract slice
module sub_cell #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] a,
    input  logic [STEP-1:0] b,
    input  logic            borrow_in,
    output logic [STEP-1:0] diff,
    output logic            borrow_out
);

    logic [STEP:0] bw;

    assign bw[0] = borrow_in;

    for (genvar i = 0; i < STEP; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end

    assign borrow_out = bw[STEP];

endmodule

// File: rtl/module_sub_seq.sv
// module_sub_seq: multi-cycle A-B subtractor with early-exit magnitude compare
module module_sub_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   out,
    output logic             equal,
    output logic             less,
    output logic             greater
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N) + 1;

    if (!step_divides(WIDTH, STEP)) begin : g_bad_step
        $error("module_sub_seq: STEP must divide WIDTH and WIDTH must be >= 2");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [WIDTH:0]   out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d, borrow_q, borrow_d;
    logic             eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;

    logic [STEP-1:0]      ca, cb, cdiff;
    logic                 cbi, cbo;
    logic [WIDTH+STEP-1:0] merged;
    logic [WIDTH-1:0]     res_next;
    logic                 accept, last, differ, finish;

    // Compare walks MSB-first with no borrow; subtract walks LSB-first chaining the borrow
    assign ca  = (mode_q == MODE_CMP) ? a_q[WIDTH-1 -: STEP] : a_q[STEP-1:0];
    assign cb  = (mode_q == MODE_CMP) ? b_q[WIDTH-1 -: STEP] : b_q[STEP-1:0];
    assign cbi = (mode_q == MODE_CMP) ? 1'b0 : borrow_q;

    sub_cell #(.STEP(STEP)) u_cell (
        .a          (ca),
        .b          (cb),
        .borrow_in  (cbi),
        .diff       (cdiff),
        .borrow_out (cbo)
    );

    assign merged   = {cdiff, res_q};
    assign res_next = merged[WIDTH+STEP-1:STEP];
    assign accept   = (state_q == IDLE) && start;
    assign last     = cnt_q == CW'(N - 1);
    assign differ   = (mode_q == MODE_CMP) && (cdiff != '0);
    assign finish   = (state_q == RUN) && (last || differ);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: IDLE -> RUN on Start, RUN -> DONE on last/differing chunk, DONE -> IDLE
    always_comb begin
        state_d = accept ? RUN : finish ? DONE : (state_q == DONE) ? IDLE : state_q;
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        busy = (state_q == RUN) || (state_q == DONE);
        done = state_q == DONE;
    end

    // Datapath registers: operands, running borrow, chunk count, result and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_SUB;
            borrow_q <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            borrow_q <= borrow_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            gt_q     <= gt_d;
        end
    end

    // Capture on Start, shift one chunk per RUN cycle, commit results on the last chunk
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        borrow_d = borrow_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        gt_d     = gt_q;
        if (accept) begin
            a_d      = a;
            b_d      = b;
            mode_d   = mode;
            borrow_d = 1'b0;
            cnt_d    = '0;
        end else if (state_q == RUN) begin
            a_d      = (mode_q == MODE_CMP) ? a_q << STEP : a_q >> STEP;
            b_d      = (mode_q == MODE_CMP) ? b_q << STEP : b_q >> STEP;
            res_d    = res_next;
            borrow_d = cbo;
            cnt_d    = cnt_q + CW'(1);
            if (finish && mode_q == MODE_SUB) begin
                out_d = {cbo, res_next};
                lt_d  = cbo;
                eq_d  = !cbo && (res_next == '0);
                gt_d  = !cbo && (res_next != '0);
            end else if (finish) begin
                eq_d = !differ;
                lt_d = differ && cbo;
                gt_d = differ && !cbo;
            end
        end
    end

    assign out     = out_q;
    assign equal   = eq_q;
    assign less    = lt_q;
    assign greater = gt_q;

endmodule

// File: tb/tb_module_sub_seq.sv
// tb_module_sub_seq: scoreboard bench for the sequential subtractor/comparator
module tb_module_sub_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s4 = 1'b0, m4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bz4, dn4, eq4, lt4, gt4;
    logic [4:0] o4;

    logic       s8 = 1'b0, m8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bz8, dn8, eq8, lt8, gt8;
    logic [8:0] o8;

    module_sub_seq #(.WIDTH(4), .STEP(1)) u4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .mode(m4), .a(a4), .b(b4),
        .busy(bz4), .done(dn4), .out(o4), .equal(eq4), .less(lt4), .greater(gt4)
    );

    module_sub_seq #(.WIDTH(8), .STEP(2)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .mode(m8), .a(a8), .b(b8),
        .busy(bz8), .done(dn8), .out(o8), .equal(eq8), .less(lt8), .greater(gt8)
    );

    typedef struct packed {
        logic [8:0] out;
        logic [2:0] f;
        int         lat;
    } exp_t;

    exp_t q4[$], q8[$];
    int checks = 0, failures = 0, cyc = 0, k4 = 0, k8 = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    // Monitor: every Done pulse pops one expected result and compares it
    always @(negedge clk) begin
        exp_t e;
        if (dn4) begin
            if (q4.size() == 0) chk("u4_spurious_done", 9'(dn4), 9'd0);
            else begin
                e = q4.pop_front();
                chk("u4_out", 9'(o4), e.out);
                chk("u4_flags", 9'({eq4, lt4, gt4}), 9'(e.f));
                chk("u4_latency", 9'(cyc - k4), 9'(e.lat));
            end
        end
        if (dn8) begin
            if (q8.size() == 0) chk("u8_spurious_done", 9'(dn8), 9'd0);
            else begin
                e = q8.pop_front();
                chk("u8_out", o8, e.out);
                chk("u8_flags", 9'({eq8, lt8, gt8}), 9'(e.f));
                chk("u8_latency", 9'(cyc - k8), 9'(e.lat));
            end
        end
    end

    task automatic wait_done(input int w);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((w == 4) ? dn4 : dn8) seen = 1;
        end
        if (!seen) chk("done_timeout", 9'd0, 9'd1);
    endtask

    // f = {equal, less, greater}
    task automatic op4(input logic m, input logic [3:0] a, input logic [3:0] b,
                       input logic [4:0] eo, input logic [2:0] ef, input int lat, input bit poke);
        @(negedge clk);
        s4 = 1'b1; m4 = m; a4 = a; b4 = b;
        @(posedge clk); #1;
        k4 = cyc;
        q4.push_back('{out: 9'(eo), f: ef, lat: lat});
        s4 = 1'b0; m4 = ~m; a4 = ~a; b4 = ~b;
        chk("u4_busy_after_start", 9'(bz4), 9'd1);
        if (poke) begin
            @(negedge clk); @(negedge clk);
            s4 = 1'b1; a4 = 4'h0; b4 = 4'hF;
            @(posedge clk); #1 s4 = 1'b0;
        end
        wait_done(4);
        chk("u4_busy_in_done", 9'(bz4), 9'd1);
        if (poke) begin
            s4 = 1'b1; a4 = 4'h1; b4 = 4'hE;
            @(posedge clk); #1 s4 = 1'b0;
            repeat (6) @(negedge clk);
        end else @(negedge clk);
        chk("u4_busy_idle", 9'(bz4), 9'd0);
    endtask

    task automatic op8(input logic m, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] eo, input logic [2:0] ef, input int lat);
        @(negedge clk);
        s8 = 1'b1; m8 = m; a8 = a; b8 = b;
        @(posedge clk); #1;
        k8 = cyc;
        q8.push_back('{out: eo, f: ef, lat: lat});
        s8 = 1'b0; m8 = ~m; a8 = ~a; b8 = ~b;
        wait_done(8);
        @(negedge clk);
        chk("u8_busy_idle", 9'(bz8), 9'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_u4_out", 9'(o4), 9'd0);
        chk("rst_u4_flags", 9'({eq4, lt4, gt4, bz4, dn4}), 9'd0);
        chk("rst_u8_out", o8, 9'd0);
        rst_n = 1'b1;

        op4(1'b0, 4'd9, 4'd3, 5'b0_0110, 3'b001, 4, 1'b0);
        op4(1'b0, 4'd3, 4'd9, 5'b1_1010, 3'b010, 4, 1'b0);
        op4(1'b1, 4'b1000, 4'b0111, 5'b1_1010, 3'b001, 1, 1'b0);
        op4(1'b1, 4'd5, 4'd5, 5'b1_1010, 3'b100, 4, 1'b0);
        op4(1'b1, 4'b0100, 4'b0110, 5'b1_1010, 3'b010, 3, 1'b0);
        op4(1'b1, 4'b0010, 4'b0011, 5'b1_1010, 3'b010, 4, 1'b0);
        op4(1'b0, 4'd5, 4'd5, 5'b0_0000, 3'b100, 4, 1'b0);
        op4(1'b0, 4'd9, 4'd3, 5'b0_0110, 3'b001, 4, 1'b1);

        op8(1'b0, 8'h00, 8'h01, 9'h1FF, 3'b010, 4);
        op8(1'b0, 8'hA5, 8'hA5, 9'h000, 3'b100, 4);
        op8(1'b1, 8'h80, 8'h7F, 9'h000, 3'b001, 1);
        op8(1'b1, 8'h12, 8'h13, 9'h000, 3'b010, 4);
        op8(1'b0, 8'd200, 8'd55, 9'h091, 3'b001, 4);

        // Abort a subtract mid-flight: outputs clear at once and no Done appears
        @(negedge clk);
        s4 = 1'b1; m4 = 1'b0; a4 = 4'd9; b4 = 4'd3;
        @(posedge clk); #1 s4 = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("abort_u4_out", 9'(o4), 9'd0);
        chk("abort_u4_flags", 9'({eq4, lt4, gt4, bz4, dn4}), 9'd0);
        chk("abort_u8_out", o8, 9'd0);
        chk("abort_u8_flags", 9'({eq8, lt8, gt8}), 9'd0);
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        op4(1'b0, 4'd12, 4'd5, 5'b0_0111, 3'b001, 4, 1'b0);

        repeat (4) @(negedge clk);
        chk("u4_queue_drained", 9'(q4.size()), 9'd0);
        chk("u8_queue_drained", 9'(q8.size()), 9'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
